lane_traffic_ctrl: RTL

Parametrised successor to the fixed ten-car instantiation in the game top level. Generates N_LANES cars, each with its own per-lane speed divider and alternating direction, with wrap-around at the screen edges. Adds frog/car collision detection, a lives/score game FSM and a frog-home request. Its outputs drive the vga_controller car inputs and the frog module.

---
 rtl/lane_traffic_ctrl_pkg.sv | 37 +++
 rtl/lane_traffic_ctrl_if.sv | 35 +++
 rtl/lane_traffic_ctrl_lane_car.sv | 89 ++++++++
 rtl/lane_traffic_ctrl.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/lane_traffic_ctrl_pkg.sv
// ============================================================================
// Module : frogger_pkg
// Brief  : Shared game types, screen constants and the lane speed-up helper.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package frogger_pkg;

    typedef logic [9:0] coord_t;

    typedef enum logic [1:0] {
        ST_PLAY = 2'd0,
        ST_HIT  = 2'd1,
        ST_OVER = 2'd2
    } game_state_t;

    localparam int c_X_MAX      = 640;
    localparam int c_CAR_W      = 32;
    localparam int c_CAR_H      = 32;
    localparam int c_FROG_W     = 32;
    localparam int c_FROG_H     = 32;
    localparam int c_LANE_Y0    = 96;
    localparam int c_LANE_PITCH = 32;
    localparam int c_GOAL_Y     = 64;

    // 1 + min(score>>2, 3): saturates at 4 once score reaches 12
    function automatic logic [2:0] speedup_step(input logic [7:0] score);
        if ((score[7:4] != 4'd0) || (score[3:2] == 2'b11)) begin
            return 3'd4;
        end
        return {1'b0, score[3:2]} + 3'd1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/lane_traffic_ctrl_if.sv
// ============================================================================
// Module : lane_traffic_ctrl_if
// Brief  : Game-side bus: frame strobe, frog position in, car/game state out.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface lane_traffic_ctrl_if #(
    parameter int N_LANES = 10
);
    logic                    tick;
    logic                    restart;
    logic [9:0]              frog_x;
    logic [9:0]              frog_y;
    logic [10*N_LANES-1:0]   car_x;
    logic [10*N_LANES-1:0]   car_y;
    logic                    hit;
    logic                    frog_home;
    logic [2:0]              lives;
    logic [7:0]              score;
    logic [1:0]              state;

    modport master (
        output tick, restart, frog_x, frog_y,
        input  car_x, car_y, hit, frog_home, lives, score, state
    );

    modport slave (
        input  tick, restart, frog_x, frog_y,
        output car_x, car_y, hit, frog_home, lives, score, state
    );

endinterface

`default_nettype wire

// File: rtl/lane_traffic_ctrl_lane_car.sv
// ============================================================================
// Module : lane_car
// Brief  : One lane: speed divider, wrapping car position, frog overlap test.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module lane_car
    import frogger_pkg::*;
#(
    parameter int X_MAX  = c_X_MAX,
    parameter int CAR_W  = c_CAR_W,
    parameter int CAR_H  = c_CAR_H,
    parameter int FROG_W = c_FROG_W,
    parameter int FROG_H = c_FROG_H
) (
    input  wire logic       clk,
    input  wire logic       reset,
    input  wire logic       en_i,
    input  wire logic       load_i,
    input  wire logic [7:0] period_i,
    input  wire logic       dir_left_i,
    input  wire coord_t     start_x_i,
    input  wire coord_t     y_i,
    input  wire logic [2:0] step_i,
    input  wire coord_t     frog_x_i,
    input  wire coord_t     frog_y_i,
    output coord_t          x_o,
    output logic            coll_o
);

    localparam logic [10:0] c_XMAX11  = 11'(X_MAX);
    localparam logic [10:0] c_CARW11  = 11'(CAR_W);
    localparam logic [10:0] c_CARH11  = 11'(CAR_H);
    localparam logic [10:0] c_FROGW11 = 11'(FROG_W);
    localparam logic [10:0] c_FROGH11 = 11'(FROG_H);

    logic [7:0]  div_q;
    coord_t      x_q;
    coord_t      x_d;
    logic [10:0] w_x11;
    logic [10:0] w_step11;
    logic [10:0] w_right;
    logic [10:0] w_right_wr;
    logic [10:0] w_left;
    logic [10:0] w_fx;
    logic [10:0] w_fy;
    logic [10:0] w_cy;

    assign w_x11    = {1'b0, x_q};
    assign w_step11 = {8'd0, step_i};
    assign w_right  = w_x11 + w_step11;

    always_comb begin
        w_right_wr = (w_right >= c_XMAX11) ? (w_right - c_XMAX11) : w_right;
        w_left     = (w_x11 >= w_step11) ? (w_x11 - w_step11)
                                         : (w_x11 + c_XMAX11 - w_step11);
        x_d        = dir_left_i ? w_left[9:0] : w_right_wr[9:0];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_q <= 8'd0;
            x_q   <= start_x_i;
        end else if (load_i) begin
            div_q <= 8'd0;
            x_q   <= start_x_i;
        end else if (en_i) begin
            if (div_q == (period_i - 8'd1)) begin
                div_q <= 8'd0;
                x_q   <= x_d;
            end else begin
                div_q <= div_q + 8'd1;
            end
        end
    end

    // Axis-aligned box overlap; 11 bits so x+width never wraps
    assign w_fx   = {1'b0, frog_x_i};
    assign w_fy   = {1'b0, frog_y_i};
    assign w_cy   = {1'b0, y_i};
    assign coll_o = (w_fx < (w_x11 + c_CARW11)) && (w_x11 < (w_fx + c_FROGW11)) &&
                    (w_fy < (w_cy + c_CARH11))  && (w_cy < (w_fy + c_FROGH11));

    assign x_o = x_q;

endmodule

`default_nettype wire

// File: rtl/lane_traffic_ctrl.sv
// ============================================================================
// Module : lane_traffic_ctrl
// Brief  : N-lane car traffic with collision, lives/score FSM and frog-home.
//          Define LANE_SPEEDUP_EN to speed cars up by 1 px every 4 goals.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module lane_traffic_ctrl
    import frogger_pkg::*;
#(
    parameter int N_LANES    = 10,
    parameter int X_MAX      = c_X_MAX,
    parameter int LANE_Y0    = c_LANE_Y0,
    parameter int LANE_PITCH = c_LANE_PITCH,
    parameter int CAR_W      = c_CAR_W,
    parameter int CAR_H      = c_CAR_H,
    parameter int FROG_W     = c_FROG_W,
    parameter int FROG_H     = c_FROG_H,
    parameter int SPEED_MAX  = 4,
    parameter int LIVES      = 3,
    parameter int HIT_TICKS  = 60,
    parameter int GOAL_Y     = c_GOAL_Y
) (
    input  wire logic           clk,
    input  wire logic           reset,
    lane_traffic_ctrl_if.slave  bus
);

    localparam int          c_TW       = $clog2(HIT_TICKS + 1);
    localparam logic [c_TW-1:0] c_HIT_LAST = c_TW'(HIT_TICKS - 1);
    localparam logic [2:0]  c_LIVES    = 3'(LIVES);
    localparam logic [10:0] c_GOAL11   = 11'(GOAL_Y);

    game_state_t       state_q;
    game_state_t       state_d;
    logic [2:0]        lives_q;
    logic [2:0]        lives_d;
    logic [7:0]        score_q;
    logic [7:0]        score_d;
    logic [c_TW-1:0]   timer_q;
    logic [c_TW-1:0]   timer_d;
    logic              armed_q;
    logic              armed_d;
    logic              coll_q;

    logic [N_LANES-1:0] w_coll;
    logic [2:0]         w_step;
    logic               w_move_en;
    logic               w_hit;
    logic               w_goal;
    logic               w_restart;
    logic               w_home;
    logic               w_frog_low;

`ifdef LANE_SPEEDUP_EN
    assign w_step = speedup_step(score_q);
`else
    assign w_step = 3'd1;
`endif

    assign w_move_en  = bus.tick && (state_q != ST_OVER);
    assign w_frog_low = ({1'b0, bus.frog_y} < c_GOAL11);

    for (genvar i = 0; i < N_LANES; i++) begin : g_lane
        localparam bit         c_DIR_LEFT = ((i % 2) == 1);
        localparam coord_t     c_START    = c_DIR_LEFT ? coord_t'(X_MAX - CAR_W) : coord_t'(0);
        localparam coord_t     c_Y        = coord_t'(LANE_Y0 + i * LANE_PITCH);
        localparam logic [7:0] c_PERIOD   = 8'((i % SPEED_MAX) + 1);

        coord_t w_x;

        lane_car #(
            .X_MAX  (X_MAX),
            .CAR_W  (CAR_W),
            .CAR_H  (CAR_H),
            .FROG_W (FROG_W),
            .FROG_H (FROG_H)
        ) u_car (
            .clk        (clk),
            .reset      (reset),
            .en_i       (w_move_en),
            .load_i     (w_restart),
            .period_i   (c_PERIOD),
            .dir_left_i (c_DIR_LEFT),
            .start_x_i  (c_START),
            .y_i        (c_Y),
            .step_i     (w_step),
            .frog_x_i   (bus.frog_x),
            .frog_y_i   (bus.frog_y),
            .x_o        (w_x),
            .coll_o     (w_coll[i])
        );

        assign bus.car_x[10*i +: 10] = w_x;
        assign bus.car_y[10*i +: 10] = c_Y;
    end

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_PLAY;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_PLAY: begin
                if (coll_q) begin
                    state_d = ST_HIT;
                end
            end
            ST_HIT: begin
                if (bus.tick && (timer_q == c_HIT_LAST)) begin
                    state_d = (lives_q == 3'd0) ? ST_OVER : ST_PLAY;
                end
            end
            ST_OVER: begin
                if (bus.restart) begin
                    state_d = ST_PLAY;
                end
            end
            default: state_d = ST_PLAY;
        endcase
    end

    // Output logic: a hit in PLAY pre-empts any goal in the same cycle
    always_comb begin
        w_hit     = 1'b0;
        w_goal    = 1'b0;
        w_restart = 1'b0;
        case (state_q)
            ST_PLAY: begin
                w_hit  = coll_q;
                w_goal = !coll_q && armed_q && w_frog_low;
            end
            ST_OVER: w_restart = bus.restart;
            default: ;
        endcase
        w_home = w_hit || w_goal || w_restart;
    end

    always_comb begin
        lives_d = lives_q;
        score_d = score_q;
        timer_d = timer_q;
        armed_d = armed_q;

        if (w_restart) begin
            lives_d = c_LIVES;
            score_d = 8'd0;
        end else if (w_hit && (lives_q != 3'd0)) begin
            lives_d = lives_q - 3'd1;
        end else if (w_goal && (score_q != 8'hFF)) begin
            score_d = score_q + 8'd1;
        end

        if (w_hit) begin
            timer_d = '0;
        end else if ((state_q == ST_HIT) && bus.tick && (timer_q != c_HIT_LAST)) begin
            timer_d = timer_q + 1'b1;
        end

        if (!w_frog_low) begin
            armed_d = 1'b1;
        end else if (w_goal) begin
            armed_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lives_q <= c_LIVES;
            score_q <= 8'd0;
            timer_q <= '0;
            armed_q <= 1'b1;
            coll_q  <= 1'b0;
        end else begin
            lives_q <= lives_d;
            score_q <= score_d;
            timer_q <= timer_d;
            armed_q <= armed_d;
            coll_q  <= |w_coll;
        end
    end

    assign bus.hit       = w_hit;
    assign bus.frog_home = w_home;
    assign bus.lives     = lives_q;
    assign bus.score     = score_q;
    assign bus.state     = state_q;

endmodule

`default_nettype wire
